// File: rtl/stream_loopback_fifo.sv
// stream_loopback_fifo
// Valid/ready loopback buffer: beats accepted upstream are stored in a
// DEPTH-entry FIFO and replayed in order downstream. An optional forced gap
// of DELAY idle cycles follows every downstream transfer.
module stream_loopback_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int DELAY = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       up_valid,
  input  logic [DW-1:0]              up_data,
  output logic                       up_ready,
  output logic                       down_valid,
  output logic [DW-1:0]              down_data,
  input  logic                       down_ready,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  // A zero DELAY still needs a one-bit counter so the gating logic stays uniform.
  localparam int GW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [GW-1:0] gap_cnt_reg;

  logic push;
  logic pop;

  // Handshake gating is built only from registered state and rst, so neither
  // up_valid nor down_ready can ripple through to the opposite port.
  always_comb begin
    up_ready   = rst & (level_reg != LW'(DEPTH));
    down_valid = (level_reg != '0) & (gap_cnt_reg == '0);
    push       = up_valid & up_ready;
    pop        = down_valid & down_ready;
    down_data  = mem[rd_ptr_reg];
    level      = level_reg;
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= up_data;
    end
  end

  // Pointers, occupancy and gap counter; reset discards any stored beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      gap_cnt_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
      // Loading only on a pop means a raised down_valid can never be withdrawn.
      if (pop) begin
        gap_cnt_reg <= GW'(DELAY);
      end else if (gap_cnt_reg != '0) begin
        gap_cnt_reg <= gap_cnt_reg - GW'(1);
      end
    end
  end

endmodule
